// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: default timing, command bytes and the
// host-transmit state encoding used by ps2_host_tx and the receiver.
package ps2_pkg;

    localparam int unsigned PS2_CLK_HZ              = 88_000_000;
    localparam int unsigned PS2_INHIBIT_CYCLES      = 8_800;
    localparam int unsigned PS2_FIRST_EDGE_CYCLES   = 1_320_000;
    localparam int unsigned PS2_EDGE_TIMEOUT_CYCLES = 176_000;
    localparam int unsigned PS2_FILTER_CYCLES       = 8;

    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_RTS     = 3'd2;
    localparam logic [2:0] S_BITS    = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    typedef enum logic [2:0] {
        TX_IDLE    = S_IDLE,
        TX_INHIBIT = S_INHIBIT,
        TX_RTS     = S_RTS,
        TX_BITS    = S_BITS,
        TX_ACK     = S_ACK,
        TX_RELEASE = S_RELEASE
    } ps2_tx_state_t;

    // Serial frame after the start bit, bit 0 first: data, odd parity, stop.
    function automatic logic [9:0] ps2_tx_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizer, glitch filter and falling-edge strobe for one PS/2 line.
// Shared by the host transmitter and the receive path.
module ps2_line_filter #(
    parameter int unsigned FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0] CNT_LAST = FW'(FILTER_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic          fall_q, fall_d;
    logic [FW-1:0] cnt_q, cnt_d;

    // Accept a new level only after a run of identical synchronized samples.
    always_comb begin
        sync_d  = {sync_q[0], line_i};
        level_d = level_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                fall_d  = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Idle PS/2 lines are pulled high, so everything resets to 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. Drives the open-drain lines
// only through pull-low enables; the tri-state buffers live at top level.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ              = PS2_CLK_HZ,
    parameter int unsigned INHIBIT_CYCLES      = PS2_INHIBIT_CYCLES,
    parameter int unsigned FIRST_EDGE_CYCLES   = PS2_FIRST_EDGE_CYCLES,
    parameter int unsigned EDGE_TIMEOUT_CYCLES = PS2_EDGE_TIMEOUT_CYCLES,
    parameter int unsigned FILTER_CYCLES       = PS2_FILTER_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int CW = $clog2(FIRST_EDGE_CYCLES + 1);

    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] INH_START = CW'(INHIBIT_CYCLES - 2);
    localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] FIRST_LIM = CW'(FIRST_EDGE_CYCLES);
    localparam logic [CW-1:0] EDGE_LIM  = CW'(EDGE_TIMEOUT_CYCLES);

    ps2_tx_state_t state_q, state_d;
    logic [9:0]    frame_q, frame_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          done_c, err_c;

    logic clk_lvl, clk_fall;
    logic data_lvl, data_fall;

    ps2_line_filter #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_clk_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_i  (ps2_clk_i),
        .level_o (clk_lvl),
        .fall_o  (clk_fall)
    );

    ps2_line_filter #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_data_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_i  (ps2_data_i),
        .level_o (data_lvl),
        .fall_o  (data_fall)
    );

    // Transfer sequencing; the shared counter times inhibit, first edge
    // and inter-edge gaps, and saturates rather than wrapping.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        idx_d     = idx_q;
        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_c    = 1'b0;
        err_c     = 1'b0;

        unique case (state_q)
            TX_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                cnt_d     = '0;
                if (tx_valid) begin
                    frame_d  = ps2_tx_frame(tx_data);
                    idx_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = TX_INHIBIT;
                end
            end
            TX_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    clk_oe_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = TX_RTS;
                end else if (cnt_q == INH_START) begin
                    data_oe_d = 1'b1;
                end
            end
            TX_RTS: begin
                if (clk_fall) begin
                    data_oe_d = ~frame_q[0];
                    idx_d     = 4'd1;
                    cnt_d     = '0;
                    state_d   = TX_BITS;
                end else if (cnt_q >= FIRST_LIM) begin
                    err_c = 1'b1;
                end
            end
            TX_BITS: begin
                if (clk_fall) begin
                    data_oe_d = ~frame_q[idx_q];
                    idx_d     = idx_q + 4'd1;
                    cnt_d     = '0;
                    if (idx_q == 4'd9) begin
                        state_d = TX_ACK;
                    end
                end else if (cnt_q >= EDGE_LIM) begin
                    err_c = 1'b1;
                end
            end
            TX_ACK: begin
                if (clk_fall) begin
                    cnt_d = '0;
                    if (!data_lvl) begin
                        state_d = TX_RELEASE;
                    end else begin
                        err_c = 1'b1;
                    end
                end else if (cnt_q >= EDGE_LIM) begin
                    err_c = 1'b1;
                end
            end
            TX_RELEASE: begin
                if (clk_lvl && data_lvl) begin
                    done_c  = 1'b1;
                    state_d = TX_IDLE;
                end else if (clk_fall) begin
                    cnt_d = '0;
                end else if (cnt_q >= EDGE_LIM) begin
                    err_c = 1'b1;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        if (err_c) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = TX_IDLE;
        end
    end

    // State and line-enable registers; reset releases both lines.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= TX_IDLE;
            frame_q   <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
        end
    end

    // Pulses come out in the last busy cycle, so tx_ready rises the
    // cycle after; they are masked while reset is held.
    assign tx_done     = done_c & rst_n;
    assign tx_err      = err_c & rst_n;
    assign tx_ready    = (state_q == TX_IDLE);
    assign busy        = ~tx_ready;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

    logic unused_c;
    assign unused_c = data_fall;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device drives the lines
// and the sampled frames are compared with a byte-level reference.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH   = 100;
    localparam int FIRST = 2000;
    localparam int EDGE  = 1000;
    localparam int FILT  = 4;
    localparam int HALF  = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err, busy;
    logic       clk_oe, data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_i, ps2_data_i;
    logic [10:0] samp;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int overlap_cnt = 0;

    assign ps2_clk_i  = dev_clk & ~clk_oe;
    assign ps2_data_i = ~dev_data_low & ~data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES      (INH),
        .FIRST_EDGE_CYCLES   (FIRST),
        .EDGE_TIMEOUT_CYCLES (EDGE),
        .FILTER_CYCLES       (FILT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .busy        (busy),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (clk_oe),
        .ps2_data_oe (data_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if ((tx_done && tx_ready) || (tx_done && tx_err)) overlap_cnt++;
    end

    initial begin
        #(10 * 200_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Line order as the device sees it: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] ref_bits(input logic [7:0] d);
        logic [10:0] b;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = d[i];
        b[9]  = ($countones(d) % 2 == 0);
        b[10] = 1'b1;
        return b;
    endfunction

    task automatic device(input bit ack, input bit glitch, input int rst_at);
        int t;
        t = 0;
        dev_data_low = 1'b0;
        while (!(ps2_clk_i && !ps2_data_i) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("rts_seen", t < 5000, 1);
        repeat (50) @(negedge clk);
        samp[0] = ps2_data_i;
        for (int i = 1; i <= 11; i++) begin
            dev_clk = 1'b0;
            if (i == rst_at) begin
                repeat (50) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                check("rst_lines", {tx_ready, busy, clk_oe, data_oe}, 4'b1000);
                check("rst_pulses", {tx_done, tx_err}, 2'b00);
                rst_n = 1'b1;
                dev_clk = 1'b1;
                return;
            end
            repeat (HALF) @(negedge clk);
            if (i <= 10) samp[i] = ps2_data_i;
            dev_clk = 1'b1;
            if (i == 11) dev_data_low = 1'b0;
            if (glitch && i <= 9) begin
                repeat (40) @(negedge clk);
                dev_clk = 1'b0;
                repeat (2) @(negedge clk);
                dev_clk = 1'b1;
                tx_data = 8'($urandom);
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                repeat (HALF - 43) @(negedge clk);
            end else if (i == 10) begin
                repeat (50) @(negedge clk);
                dev_data_low = ack;
                repeat (50) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic wait_pulse(input int bound, output int kind,
                              output int waited, output logic [3:0] post);
        kind = 0;
        waited = 0;
        while (!(tx_done || tx_err) && waited < bound) begin
            @(negedge clk);
            waited++;
        end
        if (tx_done) kind = 1;
        else if (tx_err) kind = 2;
        @(negedge clk);
        post = {tx_ready, busy, clk_oe, data_oe};
    endtask

    task automatic start_tx(input logic [7:0] d, output int hold,
                            output int ov);
        @(negedge clk);
        check("ready_before", tx_ready, 1);
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data = 8'($urandom);
        check("busy_after_accept", {busy, tx_ready}, 2'b10);
        hold = 0;
        ov = 0;
        while (clk_oe && hold < 1000) begin
            hold++;
            if (data_oe) ov++;
            @(negedge clk);
        end
    endtask

    task automatic do_frame(input logic [7:0] d, input bit ack,
                            input bit glitch, input string tag);
        int hold, ov, kind, waited, d0, e0;
        logic [3:0] post;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(d, hold, ov);
        check({tag, "_hold"}, hold, INH);
        check({tag, "_start_ovl"}, ov, 1);
        check({tag, "_start_bit"}, data_oe, 1);
        fork
            device(ack, glitch, 0);
            wait_pulse(5000, kind, waited, post);
        join
        check({tag, "_bits"}, samp, ref_bits(d));
        check({tag, "_kind"}, kind, ack ? 1 : 2);
        check({tag, "_post"}, post, 4'b1000);
        check({tag, "_done_n"}, done_cnt - d0, ack ? 1 : 0);
        check({tag, "_err_n"}, err_cnt - e0, ack ? 0 : 1);
    endtask

    initial begin
        int hold, ov, kind, waited, d0, e0, busy_n;
        logic [3:0] post;

        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_oe", {clk_oe, data_oe}, 2'b00);
        check("rst_pulses", {tx_done, tx_err}, 2'b00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        do_frame(PS2_CMD_ENABLE, 1'b1, 1'b0, "f4");
        do_frame(PS2_CMD_RESET, 1'b1, 1'b0, "ff");
        for (int k = 0; k < 4; k++) begin
            do_frame(8'($urandom), 1'b1, 1'b0, "rnd");
        end
        do_frame(8'($urandom), 1'b0, 1'b0, "nack");

        // Device never clocks after the request-to-send.
        e0 = err_cnt;
        start_tx(8'($urandom), hold, ov);
        check("noclk_hold", hold, INH);
        wait_pulse(3000, kind, waited, post);
        check("noclk_kind", kind, 2);
        check("noclk_time", waited, FIRST);
        check("noclk_post", post, 4'b1000);
        check("noclk_err_n", err_cnt - e0, 1);

        // Reset in the middle of a frame, then a normal frame.
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'h00, hold, ov);
        device(1'b1, 1'b0, 5);
        check("rst_mid_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        repeat (20) @(negedge clk);
        do_frame(PS2_CMD_ENABLE, 1'b1, 1'b0, "after_rst");

        // Clock glitches and ignored requests while busy.
        do_frame(8'($urandom), 1'b1, 1'b1, "glitch");
        busy_n = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy || clk_oe) busy_n++;
        end
        check("no_extra_tx", busy_n, 0);

        check("done_excl", overlap_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter. It sends one command byte per request (e.g. 0xF4 enable reporting, 0xFF reset) from the FPGA to the mouse over the shared open-drain PS2Clk/PS2Data lines. It is the transmit counterpart of the PS/2 receive path inside top_vga and runs in the 88 MHz pixel-clock domain. It drives the lines only through active-high pull-low enables; tri-state buffers stay at top level.

## Interface
- CLK_HZ, 88_000_000: clock frequency, documentation only.
- INHIBIT_CYCLES, 8_800: clock-low hold before start, 100 us.
- FIRST_EDGE_CYCLES, 1_320_000: maximum wait for the device's first clock edge, 15 ms.
- EDGE_TIMEOUT_CYCLES, 176_000: maximum gap between device clock falling edges, 2 ms.
- FILTER_CYCLES, 8: consecutive equal samples required to accept a line level.
- clk  input  1  system clock (88 MHz). One clock; reset is synchronous and active-low.
- rst_n  input  1  synchronous active-low reset.
- tx_data  input  8  command byte.
- tx_valid  input  1  request; accepted when tx_valid && tx_ready.
- tx_ready  output  1  high only in IDLE.
- tx_done  output  1  one-cycle pulse when the device acknowledges.
- tx_err  output  1  one-cycle pulse on missing ACK or timeout.
- busy  output  1  high in any non-IDLE state; the receiver ignores frames while this is high.
- ps2_clk_i, ps2_data_i  input  1 each  raw line levels (asynchronous).
- ps2_clk_oe, ps2_data_oe  output  1 each  1 = pull line low, 0 = release.

## Operation
- States: IDLE, INHIBIT, RTS, BITS, ACK, RELEASE.
- Edge detection:
  - Each input passes a 2-FF synchronizer, then the filter.
  - The filtered level changes only after FILTER_CYCLES identical synchronized samples.
  - A falling edge is the filtered clock going 1->0, as a 1-cycle strobe.
- IDLE: outputs released. On accept, latch tx_data, compute odd parity (~^tx_data), clear the bit index, go to INHIBIT.
  - The host has priority: a device frame in progress is aborted by the inhibit.
- INHIBIT: clk_oe=1 for INHIBIT_CYCLES. In the final cycle, also set data_oe=1 (start bit). Then go to RTS.
- RTS: clk_oe=0, data_oe=1.
  - The first device falling edge drives data bit 0 and goes to BITS.
  - If no edge arrives within FIRST_EDGE_CYCLES: error.
- BITS: on each falling edge, drive the next bit. Index 1..7 are data bits LSB first, 8 is parity, 9 is stop (data_oe=0). data_oe = ~bit.
  - The falling edge that drives the stop bit goes to ACK.
- ACK: on the next falling edge, sample filtered data.
  - 0 -> ACK ok, go to RELEASE.
  - 1 -> error.
- RELEASE: wait for filtered clk=1 and data=1, then pulse tx_done and go to IDLE.
- Error path: pulse tx_err, release both lines, go to IDLE the same cycle.
- Watchdog:
  - In BITS, ACK and RELEASE, the counter resets on every device falling edge.
  - Reaching EDGE_TIMEOUT_CYCLES -> error.
  - Counter width is ceil(log2(FIRST_EDGE_CYCLES+1)); it saturates and never wraps.
- tx_valid while busy is ignored; the request is not queued.

## Timing
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, tx_done=0, tx_err=0; state IDLE.
- Reset mid-frame releases both lines on the next clk edge. No tx_err is produced.
- Accept cycle N: clk_oe=1 from N+1. busy=1 and tx_ready=0 from N+1.
- Start bit: data_oe=1 from cycle N+INHIBIT_CYCLES. clk_oe=0 from N+INHIBIT_CYCLES+1.
- Device edge to data_oe update: 2 (sync) + FILTER_CYCLES + 1 cycles. This is well inside the device's ~40 us low half-period.
- tx_done/tx_err are single-cycle and mutually exclusive. tx_ready returns to 1 the cycle after either pulse.
- tx_done and tx_ready are never asserted together.
- Line glitches shorter than FILTER_CYCLES produce no edge.

## Structure
- ps2_pkg (shared with the receiver):
  - ps2_tx_state_t enum.
  - Command constants PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4.
  - Default timing constants.
- Sub-module ps2_line_filter (synchronizer + glitch filter + falling-edge strobe), instantiated for clock and data. The receiver reuses it.
- Top-level connection: ps2_clk_oe / ps2_data_oe drive PS2Clk / PS2Data low when 1, high-Z otherwise.

## Test plan
Bench setup: INHIBIT_CYCLES=100, FIRST_EDGE_CYCLES=2000, EDGE_TIMEOUT_CYCLES=1000, FILTER_CYCLES=4. The device model clocks at a 200-cycle period.

- Send 0xF4, model ACKs:
  - clk held low exactly 100 cycles.
  - Bits sampled on device rising edges: start 0, then 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - Single tx_done; tx_err stays 0.
- Send 0xFF: data bits all 1, parity 1; tx_done.
- Model withholds ACK (data high on 11th edge): tx_err pulses once, both oe=0, tx_ready=1 next cycle.
- Model never clocks after RTS: tx_err exactly 2000 cycles after the clock release. Lines released.
- Assert rst_n=0 during bit 4: both oe=0 next cycle, no pulses. A following 0xF4 completes normally.
- 2-cycle clock glitches during BITS and tx_valid pulses while busy: bit count unaffected, no extra transfer started.
